// File: rtl/logic_unit_pkg.sv
// ============================================================================
// Module      : logic_unit_pkg
// Description : Op encodings, parameter limits and the default-width stage
//               payload for the pipelined logic unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package logic_unit_pkg;

    localparam int c_width_min = 8;
    localparam int c_width_def = 64;
    localparam int c_depth_min = 1;
    localparam int c_depth_max = 4;
    localparam int c_pop_w_def = $clog2(c_width_def + 1);

    typedef enum logic [2:0] {
        LOP_AND  = 3'd0,
        LOP_OR   = 3'd1,
        LOP_XOR  = 3'd2,
        LOP_NOR  = 3'd3,
        LOP_NAND = 3'd4,
        LOP_XNOR = 3'd5,
        LOP_ANDN = 3'd6,
        LOP_PASS = 3'd7
    } lu_op_e;

    // Payload carried by each stage at the default width; the top module
    // re-declares it locally so WIDTH can be overridden per instance.
    typedef struct packed {
        logic [c_width_def-1:0] res;
        logic                   zero;
        logic [c_pop_w_def-1:0] pop;
    } lu_payload_t;

endpackage

`default_nettype wire

// File: rtl/logic_unit_if.sv
// ============================================================================
// Module      : logic_unit_if
// Description : Operand/result valid-ready bundle of the logic unit.
//               out_pop exists only when LOGIC_POPCOUNT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface logic_unit_if #(
    parameter int WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_zero;
`ifdef LOGIC_POPCOUNT_EN
    logic [$clog2(WIDTH+1)-1:0] out_pop;
`endif

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_zero
`ifdef LOGIC_POPCOUNT_EN
        , input out_pop
`endif
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_zero
`ifdef LOGIC_POPCOUNT_EN
        , output out_pop
`endif
    );
endinterface

`default_nettype wire

// File: rtl/logic_unit_stage.sv
// ============================================================================
// Module      : logic_unit_stage
// Description : One valid/ready register slice; loads when empty or when
//               its current beat is taken downstream.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_unit_stage
    import logic_unit_pkg::*;
#(
    parameter int PW = 66
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_up_valid,
    input  logic [PW-1:0] i_up_data,
    input  logic          i_dn_ready,
    output logic          o_dn_valid,
    output logic [PW-1:0] o_dn_data
);

    logic          r_valid;
    logic [PW-1:0] r_data;
    logic          w_load;

    assign w_load = ~r_valid | i_dn_ready;

    // Data only moves with a real beat so a drained stage keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_up_valid;
            if (i_up_valid) begin
                r_data <= i_up_data;
            end
        end
    end

    assign o_dn_valid = r_valid;
    assign o_dn_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module      : logic_unit_pipe
// Description : Pipelined 8-op bitwise logic unit with zero flag; optional
//               popcount output enabled by LOGIC_POPCOUNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    logic_unit_if.slave bus
);

`ifdef LOGIC_POPCOUNT_EN
    localparam int c_pop_w = $clog2(WIDTH + 1);
`endif

    typedef struct packed {
        logic [WIDTH-1:0]   res;
        logic               zero;
`ifdef LOGIC_POPCOUNT_EN
        logic [c_pop_w-1:0] pop;
`endif
    } payload_t;

    localparam int c_pw = $bits(payload_t);

    logic [WIDTH-1:0] w_res;
    payload_t         w_payload;
    payload_t         w_out;
    logic [DEPTH-1:0] w_sv;
    logic [DEPTH-1:0] w_dn_ready;
    logic [c_pw-1:0]  w_sd [DEPTH];
    logic             w_chain;

    always_comb begin
        w_res = '0;
        case (lu_op_e'(bus.in_op))
            LOP_AND:  w_res = bus.in_a & bus.in_b;
            LOP_OR:   w_res = bus.in_a | bus.in_b;
            LOP_XOR:  w_res = bus.in_a ^ bus.in_b;
            LOP_NOR:  w_res = ~(bus.in_a | bus.in_b);
            LOP_NAND: w_res = ~(bus.in_a & bus.in_b);
            LOP_XNOR: w_res = ~(bus.in_a ^ bus.in_b);
            LOP_ANDN: w_res = bus.in_a & ~bus.in_b;
            LOP_PASS: w_res = bus.in_a;
            default:  w_res = bus.in_a;
        endcase
    end

    always_comb begin
        w_payload      = '0;
        w_payload.res  = w_res;
        w_payload.zero = (w_res == '0);
`ifdef LOGIC_POPCOUNT_EN
        for (int i = 0; i < WIDTH; i++) begin
            w_payload.pop = w_payload.pop + c_pop_w'(w_res[i]);
        end
`endif
    end

    // Ready ripples from the output back: a stage can take a beat if it, or
    // any stage after it, holds a bubble, or if the sink is accepting.
    always_comb begin
        w_dn_ready = '0;
        w_chain    = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_dn_ready[i] = w_chain;
            w_chain       = w_chain | ~w_sv[i];
        end
    end

    assign bus.in_ready = w_chain;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic            w_up_valid;
            logic [c_pw-1:0] w_up_data;

            if (i == 0) begin : g_head
                assign w_up_valid = bus.in_valid;
                assign w_up_data  = w_payload;
            end else begin : g_body
                assign w_up_valid = w_sv[i-1];
                assign w_up_data  = w_sd[i-1];
            end

            logic_unit_stage #(
                .PW (c_pw)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_up_valid (w_up_valid),
                .i_up_data  (w_up_data),
                .i_dn_ready (w_dn_ready[i]),
                .o_dn_valid (w_sv[i]),
                .o_dn_data  (w_sd[i])
            );
        end
    endgenerate

    assign w_out         = w_sd[DEPTH-1];
    assign bus.out_valid = w_sv[DEPTH-1];
    assign bus.out_res   = w_out.res;
    assign bus.out_zero  = w_out.zero;
`ifdef LOGIC_POPCOUNT_EN
    assign bus.out_pop   = w_out.pop;
`endif

endmodule

`default_nettype wire
